if_id_queue: RTL and testbench

Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry circular fetch queue between IF and ID. It decouples fetch from decode with a valid/ready push side and a stall-driven pop side. Every fetch-side field is carried per entry: PCs, instruction, jump, delay-slot, predict, branch and jr flags. Flush empties the queue in one cycle; the empty queue presents an all-zero bubble to ID.

---
 rtl/if_id_pkg.sv | 26 ++
 rtl/if_id_ptr_ctrl.sv | 72 +++++++
 rtl/if_id_queue.sv | 123 ++++++++++++
 tb/tb_if_id_queue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared types and helpers for the IF/ID fetch queue
package if_id_pkg;

    localparam int FETCH_XLEN     = 32;
    localparam int FETCH_FLAG_CNT = 5;

    // Reference layout of one queue entry; the top level packs its
    // XLEN-wide storage words in exactly this field order.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] pc_plus;
        logic [FETCH_XLEN-1:0] pc_jump;
        logic [FETCH_XLEN-1:0] instr;
        logic                  jump;
        logic                  in_slot;
        logic                  pred_take;
        logic                  branch;
        logic                  is_jr;
    } fetch_entry_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_id_ptr_ctrl.sv
// rtl/if_id_ptr_ctrl.sv - write/read pointers and occupancy for the fetch queue
module if_id_ptr_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_valid,
    input  logic             stall_D,
    input  logic             flush_D,
    output logic             wr_en,
    output logic             f_ready,
    output logic             d_valid,
    output logic [PTR_W-1:0] wp,
    output logic [PTR_W-1:0] rp,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshakes and next pointer/count state; flush beats push and pop.
    always_comb begin
        f_ready = (count_q != CNT_W'(DEPTH));
        d_valid = (count_q != '0);
        push    = f_valid & f_ready;
        pop     = d_valid & ~stall_D;
        wr_en   = push & ~flush_D;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (flush_D) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) wp_d = ptr_inc(wp_q);
            if (pop)  rp_d = ptr_inc(rp_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    assign wp    = wp_q;
    assign rp    = rp_q;
    assign count = count_q;

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - DEPTH-entry circular IF/ID fetch queue (optional IF_ID_PERF_EN counters)
module if_id_queue
    import if_id_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_valid,
    output logic             f_ready,
    input  logic [XLEN-1:0]  pc_F,
    input  logic [XLEN-1:0]  pc_plus_F,
    input  logic [XLEN-1:0]  pc_jump_F,
    input  logic [XLEN-1:0]  instr_F,
    input  logic             jump_F,
    input  logic             F_change,
    input  logic             pred_take_F,
    input  logic             branch_F,
    input  logic             is_jr_F,
    input  logic             stall_D,
    input  logic             flush_D,
    output logic             d_valid,
    output logic [XLEN-1:0]  pc_D,
    output logic [XLEN-1:0]  pc_plus_D,
    output logic [XLEN-1:0]  pc_jump_D,
    output logic [XLEN-1:0]  instr_D,
    output logic             jump_D,
    output logic             is_in_slot_D,
    output logic             pred_take_D,
    output logic             branch_D,
    output logic             is_jr_D,
    output logic [CNT_W-1:0] count
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]      stall_cyc_o,
    output logic [31:0]      full_cyc_o,
    output logic [31:0]      flush_cnt_o
`endif
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 4 * XLEN + FETCH_FLAG_CNT;

    logic [PTR_W-1:0]   wp;
    logic [PTR_W-1:0]   rp;
    logic               wr_en;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];

    if_id_ptr_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .PTR_W (PTR_W)
    ) u_ptr (
        .clk     (clk),
        .rst     (rst),
        .f_valid (f_valid),
        .stall_D (stall_D),
        .flush_D (flush_D),
        .wr_en   (wr_en),
        .f_ready (f_ready),
        .d_valid (d_valid),
        .wp      (wp),
        .rp      (rp),
        .count   (count)
    );

    assign wr_entry = {pc_F, pc_plus_F, pc_jump_F, instr_F,
                       jump_F, F_change, pred_take_F, branch_F, is_jr_F};

    // Next storage contents: only the slot under wp changes on an accepted push.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wp] = wr_entry;
    end

    // Entry storage carries no reset; stale slots are never presented.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Head read from rp, forced to an all-zero bubble while the queue is empty.
    always_comb begin
        head = d_valid ? mem_q[rp] : '0;
        {pc_D, pc_plus_D, pc_jump_D, instr_D,
         jump_D, is_in_slot_D, pred_take_D, branch_D, is_jr_D} = head;
    end

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cyc_q, stall_cyc_d;
    logic [31:0] full_cyc_q,  full_cyc_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters; a flush does not clear them.
    always_comb begin
        stall_cyc_d = (d_valid & stall_D)         ? sat_inc32(stall_cyc_q) : stall_cyc_q;
        full_cyc_d  = (count == CNT_W'(DEPTH))    ? sat_inc32(full_cyc_q)  : full_cyc_q;
        flush_cnt_d = flush_D                     ? sat_inc32(flush_cnt_q) : flush_cnt_q;
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cyc_q <= '0;
            full_cyc_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            full_cyc_q  <= full_cyc_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cyc_o = stall_cyc_q;
    assign full_cyc_o  = full_cyc_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - directed table-driven bench for if_id_queue (DEPTH 4 and 3)
module tb_if_id_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_valid = 1'b0;
    logic [31:0] pc_F = '0, pc_plus_F = '0, pc_jump_F = '0, instr_F = '0;
    logic        jump_F = 1'b0, F_change = 1'b0, pred_take_F = 1'b0;
    logic        branch_F = 1'b0, is_jr_F = 1'b0;
    logic        stall_D = 1'b0, flush_D = 1'b0;

    logic        f_ready4, d_valid4;
    logic [31:0] pc_D4, pc_plus_D4, pc_jump_D4, instr_D4;
    logic        jump_D4, slot_D4, pred_D4, branch_D4, jr_D4;
    logic [2:0]  count4;

    logic        f_ready3, d_valid3;
    logic [31:0] pc_D3, pc_plus_D3, pc_jump_D3, instr_D3;
    logic        jump_D3, slot_D3, pred_D3, branch_D3, jr_D3;
    logic [1:0]  count3;

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cyc4, full_cyc4, flush_cnt4;
    logic [31:0] stall_cyc3, full_cyc3, flush_cnt3;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_id_queue #(.XLEN(32), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .f_valid(f_valid), .f_ready(f_ready4),
        .pc_F(pc_F), .pc_plus_F(pc_plus_F), .pc_jump_F(pc_jump_F), .instr_F(instr_F),
        .jump_F(jump_F), .F_change(F_change), .pred_take_F(pred_take_F),
        .branch_F(branch_F), .is_jr_F(is_jr_F), .stall_D(stall_D), .flush_D(flush_D),
        .d_valid(d_valid4), .pc_D(pc_D4), .pc_plus_D(pc_plus_D4), .pc_jump_D(pc_jump_D4),
        .instr_D(instr_D4), .jump_D(jump_D4), .is_in_slot_D(slot_D4),
        .pred_take_D(pred_D4), .branch_D(branch_D4), .is_jr_D(jr_D4), .count(count4)
`ifdef IF_ID_PERF_EN
        , .stall_cyc_o(stall_cyc4), .full_cyc_o(full_cyc4), .flush_cnt_o(flush_cnt4)
`endif
    );

    if_id_queue #(.XLEN(32), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .f_valid(f_valid), .f_ready(f_ready3),
        .pc_F(pc_F), .pc_plus_F(pc_plus_F), .pc_jump_F(pc_jump_F), .instr_F(instr_F),
        .jump_F(jump_F), .F_change(F_change), .pred_take_F(pred_take_F),
        .branch_F(branch_F), .is_jr_F(is_jr_F), .stall_D(stall_D), .flush_D(flush_D),
        .d_valid(d_valid3), .pc_D(pc_D3), .pc_plus_D(pc_plus_D3), .pc_jump_D(pc_jump_D3),
        .instr_D(instr_D3), .jump_D(jump_D3), .is_in_slot_D(slot_D3),
        .pred_take_D(pred_D3), .branch_D(branch_D3), .is_jr_D(jr_D3), .count(count3)
`ifdef IF_ID_PERF_EN
        , .stall_cyc_o(stall_cyc3), .full_cyc_o(full_cyc3), .flush_cnt_o(flush_cnt3)
`endif
    );

    function automatic logic [31:0] pc_of(input int i);
        return 32'h0040_0000 + 32'(4 * i);
    endfunction
    function automatic logic [31:0] instr_of(input int i);
        return 32'hA500_0000 ^ 32'(i * 32'h0001_0203);
    endfunction
    function automatic logic [4:0] flags_of(input int i);
        return 5'((i * 7 + 3) % 32);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fv, input int idx, input logic st, input logic fl);
        logic [4:0] f;
        f          = flags_of(idx);
        f_valid    = fv;
        pc_F       = pc_of(idx);
        pc_plus_F  = pc_of(idx) + 32'd4;
        pc_jump_F  = pc_of(idx) ^ 32'h0000_1000;
        instr_F    = instr_of(idx);
        {jump_F, F_change, pred_take_F, branch_F, is_jr_F} = f;
        stall_D    = st;
        flush_D    = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        #3;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic fv;
        int   idx;
        logic st;
        logic fl;
        logic exp_valid;
        int   exp_idx;
        int   exp_count;
        logic exp_ready;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [4:0] exp_flags;
        // fv idx st fl | valid head count ready   (DEPTH=4)
        vecs[0]  = '{1'b1, 0,  1'b0, 1'b0, 1'b1, 0,  1, 1'b1};
        vecs[1]  = '{1'b0, 0,  1'b0, 1'b0, 1'b0, 0,  0, 1'b1};
        vecs[2]  = '{1'b1, 1,  1'b1, 1'b0, 1'b1, 1,  1, 1'b1};
        vecs[3]  = '{1'b1, 2,  1'b1, 1'b0, 1'b1, 1,  2, 1'b1};
        vecs[4]  = '{1'b1, 3,  1'b1, 1'b0, 1'b1, 1,  3, 1'b1};
        vecs[5]  = '{1'b1, 4,  1'b1, 1'b0, 1'b1, 1,  4, 1'b0};
        vecs[6]  = '{1'b1, 5,  1'b1, 1'b0, 1'b1, 1,  4, 1'b0};
        vecs[7]  = '{1'b0, 0,  1'b0, 1'b0, 1'b1, 2,  3, 1'b1};
        vecs[8]  = '{1'b1, 6,  1'b0, 1'b0, 1'b1, 3,  3, 1'b1};
        vecs[9]  = '{1'b0, 0,  1'b0, 1'b0, 1'b1, 4,  2, 1'b1};
        vecs[10] = '{1'b0, 0,  1'b0, 1'b0, 1'b1, 6,  1, 1'b1};
        vecs[11] = '{1'b1, 7,  1'b1, 1'b0, 1'b1, 6,  2, 1'b1};
        vecs[12] = '{1'b1, 8,  1'b1, 1'b0, 1'b1, 6,  3, 1'b1};
        vecs[13] = '{1'b1, 9,  1'b1, 1'b1, 1'b0, 0,  0, 1'b1};
        vecs[14] = '{1'b0, 0,  1'b0, 1'b0, 1'b0, 0,  0, 1'b1};
        vecs[15] = '{1'b1, 10, 1'b0, 1'b0, 1'b1, 10, 1, 1'b1};

        // Reset state
        drive(1'b0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_d_valid", 32'(d_valid4), 32'd0);
        chk("rst_f_ready", 32'(f_ready4), 32'd1);
        chk("rst_count",   32'(count4),   32'd0);
        chk("rst_pc_D",    pc_D4,         32'd0);
        chk("rst_instr_D", instr_D4,      32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table: push/pop, stall-until-full, reject on full, flush with push
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].fv, vecs[i].idx, vecs[i].st, vecs[i].fl);
            tick();
            exp_flags = vecs[i].exp_valid ? flags_of(vecs[i].exp_idx) : 5'd0;
            chk($sformatf("v%0d_d_valid", i), 32'(d_valid4), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_count", i),   32'(count4),   32'(vecs[i].exp_count));
            chk($sformatf("v%0d_f_ready", i), 32'(f_ready4), 32'(vecs[i].exp_ready));
            chk($sformatf("v%0d_pc_D", i), pc_D4,
                vecs[i].exp_valid ? pc_of(vecs[i].exp_idx) : 32'd0);
            chk($sformatf("v%0d_pc_plus_D", i), pc_plus_D4,
                vecs[i].exp_valid ? pc_of(vecs[i].exp_idx) + 32'd4 : 32'd0);
            chk($sformatf("v%0d_pc_jump_D", i), pc_jump_D4,
                vecs[i].exp_valid ? (pc_of(vecs[i].exp_idx) ^ 32'h0000_1000) : 32'd0);
            chk($sformatf("v%0d_instr_D", i), instr_D4,
                vecs[i].exp_valid ? instr_of(vecs[i].exp_idx) : 32'd0);
            chk($sformatf("v%0d_flags", i),
                32'({jump_D4, slot_D4, pred_D4, branch_D4, jr_D4}), 32'(exp_flags));
        end

        // Wrap-around with DEPTH=3 under continuous flow
        pulse_reset();
        drive(1'b1, 20, 1'b0, 1'b0);
        tick();
        chk("wrap_first_pc", pc_D3, pc_of(20));
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 20 + k, 1'b0, 1'b0);
            tick();
            chk($sformatf("wrap%0d_pc", k),    pc_D3,        pc_of(20 + k));
            chk($sformatf("wrap%0d_instr", k), instr_D3,     instr_of(20 + k));
            chk($sformatf("wrap%0d_count", k), 32'(count3),  32'd1);
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        tick();
        chk("wrap_drain_valid", 32'(d_valid3), 32'd0);

        // Async reset between edges with two entries queued
        pulse_reset();
        drive(1'b1, 30, 1'b1, 1'b0);
        tick();
        drive(1'b1, 31, 1'b1, 1'b0);
        tick();
        chk("arst_pre_count", 32'(count4), 32'd2);
        drive(1'b0, 0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_d_valid", 32'(d_valid4), 32'd0);
        chk("arst_instr_D", instr_D4,      32'd0);
        chk("arst_count",   32'(count4),   32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef IF_ID_PERF_EN
        // Performance counters: 5 stalled cycles, 2 flushes, then saturation
        drive(1'b1, 40, 1'b1, 1'b0);
        tick();
        drive(1'b0, 0, 1'b1, 1'b0);
        repeat (5) tick();
        drive(1'b0, 0, 1'b0, 1'b1);
        repeat (2) tick();
        drive(1'b0, 0, 1'b0, 1'b0);
        chk("perf_stall_cyc", stall_cyc4, 32'd5);
        chk("perf_flush_cnt", flush_cnt4, 32'd2);
        chk("perf_full_cyc",  full_cyc4,  32'd0);
        force dut4.stall_cyc_q = 32'hFFFF_FFFF;
        #1;
        release dut4.stall_cyc_q;
        drive(1'b1, 41, 1'b1, 1'b0);
        tick();
        drive(1'b0, 0, 1'b1, 1'b0);
        tick();
        chk("perf_stall_sat", stall_cyc4, 32'hFFFF_FFFF);
        drive(1'b0, 0, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
